video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator for the video path. It divides the core clock into a pixel enable and keeps internal H/V counters that lock to the PPU's external beam counters. When the PPU stops supplying frames, it falls back to free-running timing. From the selected position it produces registered blanking (with per-edge crop), sync and padding flags for the palette/mixer stage, and it supports both NTSC and PAL frame geometry.

## Interface
Parameters:
- CE_DIV, 4: core clocks per pixel; must be ≥2.
- CNT_W, 10: width of the position counters.
- H_TOTAL, 341: pixels per line.
- V_TOTAL_NTSC, 262: lines per frame in NTSC mode.
- V_TOTAL_PAL, 312: lines per frame in PAL mode.
- H_VIS, 256: image pixels per line; pixels at hc ≥ H_VIS are padding.
- V_VIS, 240: visible lines.
- HS_START, 278: hc at which hsync rises.
- HS_END, 303: hc at which hsync falls.
- VS_START_NTSC, 243: first vsync line in NTSC mode.
- VS_START_PAL, 270: first vsync line in PAL mode.
- VS_LEN, 3: vsync length in lines.
- EXT_WRAP, 511: external vertical count value that precedes 0 at frame start.
- LOCK_FRAMES, 3: consecutive missed frames before lock is dropped.

Ports:
- clk, in, 1: core clock.
- reset_n, in, 1: asynchronous, active-low reset.
- pal_video, in, 1: 1 selects PAL frame geometry.
- soft_reset, in, 1: core reset request.
- ext_h, in, 9: PPU horizontal counter.
- ext_v, in, 9: PPU vertical counter.
- crop_en, in, 1: enables the crop inputs.
- crop_left, in, 4: pixels blanked at the left edge.
- crop_right, in, 4: pixels blanked at the right edge.
- crop_top, in, 4: lines blanked at the top.
- crop_bot, in, 4: lines blanked at the bottom.
- ce_pix, out, 1: pixel enable, one clk wide.
- hc, out, CNT_W: selected horizontal position.
- vc, out, CNT_W: selected vertical position.
- hblank, out, 1: registered horizontal blank.
- vblank, out, 1: registered vertical blank.
- hsync, out, 1: registered horizontal sync.
- vsync, out, 1: registered vertical sync.
- is_padding, out, 1: high when hc ≥ H_VIS.
- locked, out, 1: high while timing follows the external counters.
- frame_start, out, 1: one-clk pulse at internal (0,0).
- hold_reset, out, 1: downstream reset hold.

## Operation
**Pixel divider**
- div counts 0..CE_DIV-1 and wraps to 0.
- ce_pix is registered high for the single clk in which div==0.
- All counter, lock and flag updates below happen only on ce_pix.

**Internal counters h, v**
- h increments each ce_pix; at H_TOTAL-1 it wraps to 0 and v advances.
- v wraps to 0 after V_TOTAL-1, where V_TOTAL follows pal_video.
- A pal_video change takes effect at the next v wrap compare.
- If v ≥ V_TOTAL after a mode switch, v wraps on the next line end.

**Lock**
- A frame-sync event is: previous sampled ext_v == EXT_WRAP and current ext_v == 0.
- On a frame-sync event: h←0, v←0, miss←0, locked←1. The event takes priority over a simultaneous wrap.
- On an internal v wrap with no event in the same cycle: miss increments, saturating at LOCK_FRAMES.
- When miss reaches LOCK_FRAMES, locked←0.

**Position select**
- hc = locked && !soft_reset ? ext_h (zero-extended) : h.
- vc follows the same rule with ext_v and v.

**Flags**, registered on ce_pix from the current hc/vc:
- Effective crops cl, cr, ct, cb equal the crop inputs when crop_en is high, otherwise 0.
- hblank = hc < cl || hc ≥ H_VIS-cr || hc ≥ H_TOTAL (padding is blanked).
- vblank = vc < ct || vc ≥ V_VIS-cb.
- hsync←1 when hc==HS_START; hsync←0 when hc==HS_END.
- On the hc==HS_START cycle, vsync is loaded with (vs_start ≤ vc < vs_start+VS_LEN), where vs_start follows pal_video.
- is_padding = hc ≥ H_VIS, combinational from hc.

**frame_start and hold_reset**
- frame_start pulses for one clk on the ce_pix in which internal h and v become 0 (wrap or frame-sync event).
- hold_reset←1 while soft_reset is high.
- hold_reset←0 in the first cycle in which internal h==0 && v==0 and soft_reset is low.

**Reset (reset_n low)**
- div, h, v, miss: 0.
- locked: 0.
- All outputs 0, except hold_reset, which is 1.
- The sampled ext_v register is set to 0.

## Timing
- Latency from hc/vc to hblank, vblank, hsync and vsync is one ce_pix.
- The first ce_pix occurs CE_DIV clks after reset_n deasserts.
- Lock acquisition: locked rises on the same ce_pix that detects the frame-sync event.
- Loss of lock: locked falls on the ce_pix of the LOCK_FRAMES-th consecutive internal v wrap without an event.
- Crop and pal_video are sampled every ce_pix; software changes them only during vblank.
- Combinational paths: is_padding, hc and vc only; every other output is a flop.

## Test plan
- **Divider:** CE_DIV=4, reset_n released → ce_pix high at clk 4, 8, 12, …, each pulse one clk wide.
- **Free run, NTSC:** no ext events, pal_video=0 → locked stays 0; frame_start every 341×262×4 = 357368 clks; vsync high on lines 243–245 only.
- **Lock, then PAL loss:** drive ext_v 511→0 → locked=1 and h=v=0 on that ce_pix. Stop events with pal_video=1 → locked falls after 3×341×312 ce_pix; vsync then covers lines 270–272.
- **Crop:** crop_en=1, crop_left=8, crop_right=8, crop_top=8, crop_bot=8 → hblank low only for hc 8..247 and vblank low only for vc 8..231, each observed one ce_pix later. With crop_en=0 → hblank low for 0..255, vblank low for 0..239.
- **hold_reset:** assert soft_reset mid-frame, release at h=100, v=50 → hold_reset stays 1 until internal (0,0), then drops; hc follows internal h while soft_reset is high.
- **Async reset mid-frame:** pull reset_n low at arbitrary div/h/v → all outputs 0 and hold_reset 1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable divider, free-running H/V counters that
// lock to the PPU's beam counters, and registered blank/sync/padding flags.
module video_timing_gen #(
  parameter int unsigned CE_DIV        = 4,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned H_TOTAL       = 341,
  parameter int unsigned V_TOTAL_NTSC  = 262,
  parameter int unsigned V_TOTAL_PAL   = 312,
  parameter int unsigned H_VIS         = 256,
  parameter int unsigned V_VIS         = 240,
  parameter int unsigned HS_START      = 278,
  parameter int unsigned HS_END        = 303,
  parameter int unsigned VS_START_NTSC = 243,
  parameter int unsigned VS_START_PAL  = 270,
  parameter int unsigned VS_LEN        = 3,
  parameter int unsigned EXT_WRAP      = 511,
  parameter int unsigned LOCK_FRAMES   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pal_video,
  input  logic             soft_reset,
  input  logic [8:0]       ext_h,
  input  logic [8:0]       ext_v,
  input  logic             crop_en,
  input  logic [3:0]       crop_left,
  input  logic [3:0]       crop_right,
  input  logic [3:0]       crop_top,
  input  logic [3:0]       crop_bot,
  output logic             ce_pix,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             is_padding,
  output logic             locked,
  output logic             frame_start,
  output logic             hold_reset
);

  localparam int unsigned DIV_W  = $clog2(CE_DIV);
  localparam int unsigned MISS_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CE_DIV - 1);
  localparam logic [MISS_W-1:0] MISS_MAX    = MISS_W'(LOCK_FRAMES);
  localparam logic [MISS_W-1:0] MISS_ONE    = MISS_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_TOT_W     = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0]  H_VIS_W     = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0]  V_VIS_W     = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0]  V_LAST_NTSC = CNT_W'(V_TOTAL_NTSC - 1);
  localparam logic [CNT_W-1:0]  V_LAST_PAL  = CNT_W'(V_TOTAL_PAL - 1);
  localparam logic [CNT_W-1:0]  HS_START_W  = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0]  HS_END_W    = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0]  VS_NTSC_W   = CNT_W'(VS_START_NTSC);
  localparam logic [CNT_W-1:0]  VS_PAL_W    = CNT_W'(VS_START_PAL);
  localparam logic [CNT_W-1:0]  VS_LEN_W    = CNT_W'(VS_LEN);
  localparam logic [8:0]        EXT_WRAP_W  = 9'(EXT_WRAP);

  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  h;
  logic [CNT_W-1:0]  v;
  logic [MISS_W-1:0] miss;
  logic [8:0]        ext_v_q;

  logic              use_ext_c;
  logic              line_end_c;
  logic              wrap_c;
  logic              sync_evt_c;
  logic [CNT_W-1:0]  v_last_c;
  logic [CNT_W-1:0]  vs_start_c;
  logic [CNT_W-1:0]  cl_c;
  logic [CNT_W-1:0]  cr_c;
  logic [CNT_W-1:0]  ct_c;
  logic [CNT_W-1:0]  cb_c;
  logic              hblank_c;
  logic              vblank_c;
  logic              vsync_c;

  // Position select, frame geometry and flag terms from the current position
  always_comb begin
    use_ext_c  = locked && !soft_reset;
    hc         = use_ext_c ? CNT_W'(ext_h) : h;
    vc         = use_ext_c ? CNT_W'(ext_v) : v;
    is_padding = (hc >= H_VIS_W);

    v_last_c   = pal_video ? V_LAST_PAL : V_LAST_NTSC;
    vs_start_c = pal_video ? VS_PAL_W : VS_NTSC_W;
    line_end_c = (h == H_LAST);
    wrap_c     = line_end_c && (v >= v_last_c);
    sync_evt_c = (ext_v_q == EXT_WRAP_W) && (ext_v == 9'd0);

    cl_c = crop_en ? CNT_W'(crop_left)  : '0;
    cr_c = crop_en ? CNT_W'(crop_right) : '0;
    ct_c = crop_en ? CNT_W'(crop_top)   : '0;
    cb_c = crop_en ? CNT_W'(crop_bot)   : '0;

    hblank_c = (hc < cl_c) || (hc >= (H_VIS_W - cr_c)) || (hc >= H_TOT_W);
    vblank_c = (vc < ct_c) || (vc >= (V_VIS_W - cb_c));
    vsync_c  = (vc >= vs_start_c) && (vc < (vs_start_c + VS_LEN_W));
  end

  // Pixel divider; ce_pix is high for the clk in which div is 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else begin
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      ce_pix <= (div == DIV_LAST);
    end
  end

  // Internal H/V counters, frame-sync lock tracking and frame_start pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h           <= '0;
      v           <= '0;
      miss        <= '0;
      locked      <= 1'b0;
      ext_v_q     <= 9'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (ce_pix) begin
        ext_v_q <= ext_v;
        if (sync_evt_c) begin
          h           <= '0;
          v           <= '0;
          miss        <= '0;
          locked      <= 1'b1;
          frame_start <= 1'b1;
        end else begin
          if (line_end_c) begin
            h <= '0;
            v <= wrap_c ? '0 : v + CNT_ONE;
          end else begin
            h <= h + CNT_ONE;
          end
          if (wrap_c) begin
            frame_start <= 1'b1;
            if (miss != MISS_MAX) miss <= miss + MISS_ONE;
            if (miss >= (MISS_MAX - MISS_ONE)) locked <= 1'b0;
          end
        end
      end
    end
  end

  // Blank and sync flags, one ce_pix behind the selected position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hblank <= 1'b0;
      vblank <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (ce_pix) begin
      hblank <= hblank_c;
      vblank <= vblank_c;
      if (hc == HS_START_W) begin
        hsync <= 1'b1;
        vsync <= vsync_c;
      end else if (hc == HS_END_W) begin
        hsync <= 1'b0;
      end
    end
  end

  // Downstream reset hold, released only at the internal frame origin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reset <= 1'b1;
    end else if (soft_reset) begin
      hold_reset <= 1'b1;
    end else if ((h == '0) && (v == '0)) begin
      hold_reset <= 1'b0;
    end
  end

endmodule
